serial_link_payload_dispatcher: RTL and testbench
=================================================

Name: serial_link_payload_dispatcher

Overview:
- Receive-side counterpart of the network-layer packer: consumes packed AXIS payloads from the link (one AXI channel beat plus an optional piggy-backed B response) and dispatches each onto its own output channel.
- Each output channel (AW, W, AR, R, B) has its own FIFO, so a two-channel payload is accepted in one handshake and never needs an in-flight synchronisation state.
- Sits between the data link layer's AXIS output and the AXI request/response ports of the network layer.
- Emits per-channel free pulses for upstream credit accounting.

Parameters:
- AxiChW, 64, width of the packed AXI channel field (widest of AW/W/AR/R).
- BW, 8, width of the B response field.
- Depth, 4, entries per channel FIFO; power of two, ≥2.
- ErrCntW, 8, width of the illegal-tag counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- in_valid_i  in  1  payload valid.
- in_ready_o  out  1  payload accepted when high with in_valid_i.
- in_hdr_i  in  3  tag: 0 Idle, 1 AW, 2 W, 3 AR, 4 R, 5–7 illegal.
- in_axi_ch_i  in  AxiChW  channel beat.
- in_b_valid_i  in  1  B field present.
- in_b_i  in  BW  B response.
- {aw,w,ar,r}_valid_o  out  1 each  per-channel output valid.
- {aw,w,ar,r}_ready_i  in  1 each  per-channel output ready.
- {aw,w,ar,r}_data_o  out  AxiChW each  per-channel beat.
- b_valid_o  out  1  B output valid.
- b_ready_i  in  1  B output ready.
- b_data_o  out  BW  B response.
- freed_o  out  5  one-cycle pulse per channel on output handshake; bit order {B,R,AR,W,AW} = [4:0].
- credit_only_o  out  1  pulse when an Idle payload without B is accepted.
- err_o  out  1  sticky; set on acceptance of an illegal tag.
- err_cnt_o  out  ErrCntW  illegal tags accepted; saturates at all-ones.

Behaviour:
- Reset:
  - All FIFOs empty.
  - All *_valid_o, freed_o, credit_only_o and err_o are 0; err_cnt_o is 0.
  - Reset mid-transfer discards all buffered beats; no free pulses are emitted for them.
- Ready:
  - ch_ok = 1 for tags Idle or 5–7; otherwise ch_ok = !full of the tagged FIFO.
  - b_ok = !in_b_valid_i | !full(B).
  - in_ready_o = ch_ok & b_ok.
  - in_ready_o is combinational on the header fields but never on in_valid_i.
- Accept (in_valid_i & in_ready_o):
  - Tag 1–4 pushes in_axi_ch_i into the matching FIFO.
  - in_b_valid_i pushes in_b_i into the B FIFO in the same cycle.
  - The push is atomic: neither field is pushed unless both fit.
- Idle tag without B: accepted and discarded; credit_only_o pulses in the next cycle (registered).
- Idle tag with B: only B is pushed.
- Illegal tag: the channel field is dropped, B is still pushed if present; err_o sets and err_cnt_o increments (saturating), both visible the cycle after acceptance.
- Latency: a beat accepted in cycle N is presented on its output in N+1 at the earliest. No fall-through.
- Output: valid = FIFO non-empty; data is the FIFO head and stays stable while valid & !ready. Order within each channel is preserved; there is no ordering between channels.
- freed_o[k]: registered, asserted in cycle N+1 for an output handshake in cycle N.
- Full/empty and simultaneous push/pop:
  - A full FIFO being popped in the same cycle still reports not-full only next cycle; ready is computed from registered full flags, with no bypass.
  - An empty FIFO pushed and popped in the same cycle is impossible, because valid needs a non-empty FIFO.
- FIFO pointers: log2(Depth)+1 bits; wrap at 2·Depth. Full when the MSBs differ and the low bits are equal.

Test Plan:
- Idle with b_valid=0 → in_ready_o=1 → credit_only_o=1 one cycle later; no output valids.
- hdr=1, axi_ch=0xA5, b_valid=1, b=0x3 → aw_valid_o and b_valid_o both rise next cycle with data 0xA5 and 0x3; hold ready low 3 cycles and check data is stable → on handshake, freed_o=5'b10001 one cycle later.
- W with w_ready_i=0: push Depth=4 beats 1..4 → in_ready_o=0 for a 5th W but 1 for an AR; release w_ready → beats emerge in order 1,2,3,4.
- B FIFO full with hdr=R, b_valid=1 → in_ready_o=0 and the R FIFO is not pushed; pop one B → in_ready_o=1 the cycle after; both are pushed.
- hdr=6 ×300 → err_o=1 and err_cnt_o saturates at 255; outputs stay idle.
- Assert rst_ni low with 2 AW beats buffered → aw_valid_o=0 immediately (asynchronous), no freed_o pulses; normal operation after release.

Source files
------------

// File: rtl/serial_link_payload_dispatcher.sv
// Receive-side payload dispatcher: splits packed link payloads (channel beat + optional B)
// into per-channel FIFOs and reports output handshakes as free pulses for credit return.

module serial_link_payload_dispatcher_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned Depth = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [Depth-1:0][W-1:0] mem_q, mem_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[IdxW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[IdxW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module serial_link_payload_dispatcher #(
    parameter int unsigned AxiChW  = 64,
    parameter int unsigned BW      = 8,
    parameter int unsigned Depth   = 4,
    parameter int unsigned ErrCntW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         in_hdr_i,
    input  logic [AxiChW-1:0]  in_axi_ch_i,
    input  logic               in_b_valid_i,
    input  logic [BW-1:0]      in_b_i,
    output logic               aw_valid_o,
    input  logic               aw_ready_i,
    output logic [AxiChW-1:0]  aw_data_o,
    output logic               w_valid_o,
    input  logic               w_ready_i,
    output logic [AxiChW-1:0]  w_data_o,
    output logic               ar_valid_o,
    input  logic               ar_ready_i,
    output logic [AxiChW-1:0]  ar_data_o,
    output logic               r_valid_o,
    input  logic               r_ready_i,
    output logic [AxiChW-1:0]  r_data_o,
    output logic               b_valid_o,
    input  logic               b_ready_i,
    output logic [BW-1:0]      b_data_o,
    output logic [4:0]         freed_o,
    output logic               credit_only_o,
    output logic               err_o,
    output logic [ErrCntW-1:0] err_cnt_o
);
    localparam logic [2:0] TagIdle = 3'd0;
    localparam int unsigned NumCh  = 4;

    logic [NumCh-1:0][AxiChW-1:0] ch_data;
    logic [NumCh-1:0]             ch_push, ch_pop, ch_empty, ch_full, ch_ready;
    logic                         b_push, b_pop, b_empty, b_full;
    logic                         hdr_is_ch, hdr_illegal, ch_ok, b_ok, accept;
    logic [1:0]                   ch_sel;

    logic [4:0]         freed_q, freed_d;
    logic               credit_only_q, credit_only_d;
    logic               err_q, err_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

    // Tags 1..4 map to FIFO index 0..3 (AW, W, AR, R).
    assign hdr_is_ch   = (in_hdr_i >= 3'd1) && (in_hdr_i <= 3'd4);
    assign hdr_illegal = (in_hdr_i >= 3'd5);
    assign ch_sel      = in_hdr_i[1:0] - 2'd1;

    // Readiness uses only registered full flags, never in_valid_i.
    assign ch_ok      = !hdr_is_ch || !ch_full[ch_sel];
    assign b_ok       = !in_b_valid_i || !b_full;
    assign in_ready_o = ch_ok && b_ok;
    assign accept     = in_valid_i && in_ready_o;

    assign ch_ready = {r_ready_i, ar_ready_i, w_ready_i, aw_ready_i};
    assign ch_pop   = ~ch_empty & ch_ready;
    assign b_push   = accept && in_b_valid_i;
    assign b_pop    = !b_empty && b_ready_i;

    always_comb begin
        ch_push = '0;
        if (accept && hdr_is_ch) begin
            ch_push[ch_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NumCh; k++) begin : g_ch
        serial_link_payload_dispatcher_fifo #(
            .W     (AxiChW),
            .Depth (Depth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (ch_push[k]),
            .data_i  (in_axi_ch_i),
            .pop_i   (ch_pop[k]),
            .data_o  (ch_data[k]),
            .empty_o (ch_empty[k]),
            .full_o  (ch_full[k])
        );
    end

    serial_link_payload_dispatcher_fifo #(
        .W     (BW),
        .Depth (Depth)
    ) u_b_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (b_push),
        .data_i  (in_b_i),
        .pop_i   (b_pop),
        .data_o  (b_data_o),
        .empty_o (b_empty),
        .full_o  (b_full)
    );

    assign aw_valid_o = !ch_empty[0];
    assign w_valid_o  = !ch_empty[1];
    assign ar_valid_o = !ch_empty[2];
    assign r_valid_o  = !ch_empty[3];
    assign b_valid_o  = !b_empty;
    assign aw_data_o  = ch_data[0];
    assign w_data_o   = ch_data[1];
    assign ar_data_o  = ch_data[2];
    assign r_data_o   = ch_data[3];

    always_comb begin
        freed_d       = {b_pop, ch_pop};
        credit_only_d = accept && (in_hdr_i == TagIdle) && !in_b_valid_i;
        err_d         = err_q || (accept && hdr_illegal);
        err_cnt_d     = err_cnt_q;
        if (accept && hdr_illegal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ErrCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freed_q       <= '0;
            credit_only_q <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            freed_q       <= freed_d;
            credit_only_q <= credit_only_d;
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign freed_o       = freed_q;
    assign credit_only_o = credit_only_q;
    assign err_o         = err_q;
    assign err_cnt_o     = err_cnt_q;
endmodule

// File: tb/tb_serial_link_payload_dispatcher.sv
// Scoreboard bench: stimulus pushes expected beats per channel, a negedge monitor pops
// and compares on every output handshake and checks the registered free pulses.

module tb_serial_link_payload_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  in_hdr = 3'd0;
    logic [63:0] in_ch = '0;
    logic        in_bv = 1'b0;
    logic [7:0]  in_b = '0;
    logic        aw_valid, w_valid, ar_valid, r_valid, b_valid;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0, r_ready = 1'b0, b_ready = 1'b0;
    logic [63:0] aw_data, w_data, ar_data, r_data;
    logic [7:0]  b_data;
    logic [4:0]  freed;
    logic        credit_only, err;
    logic [7:0]  err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] q_aw[$], q_w[$], q_ar[$], q_r[$];
    logic [7:0]  q_b[$];
    logic [4:0]  prev_hs = '0;

    always #5 clk = ~clk;

    serial_link_payload_dispatcher dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_hdr_i(in_hdr),
        .in_axi_ch_i(in_ch), .in_b_valid_i(in_bv), .in_b_i(in_b),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_data_o(aw_data),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_data_o(ar_data),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_data_o(b_data),
        .freed_o(freed), .credit_only_o(credit_only), .err_o(err), .err_cnt_o(err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake; free pulses must echo last cycle's handshakes.
    always @(negedge clk) begin
        logic [4:0] hs;
        if (!rst_n) begin
            prev_hs = '0;
        end else begin
            chk("freed", 64'(freed), 64'(prev_hs));
            hs = {b_valid & b_ready, r_valid & r_ready, ar_valid & ar_ready,
                  w_valid & w_ready, aw_valid & aw_ready};
            if (hs[0]) begin
                if (q_aw.size() == 0) chk("aw_unexpected", 64'(aw_data), 64'hDEAD);
                else chk("aw_data", aw_data, q_aw.pop_front());
            end
            if (hs[1]) begin
                if (q_w.size() == 0) chk("w_unexpected", 64'(w_data), 64'hDEAD);
                else chk("w_data", w_data, q_w.pop_front());
            end
            if (hs[2]) begin
                if (q_ar.size() == 0) chk("ar_unexpected", 64'(ar_data), 64'hDEAD);
                else chk("ar_data", ar_data, q_ar.pop_front());
            end
            if (hs[3]) begin
                if (q_r.size() == 0) chk("r_unexpected", 64'(r_data), 64'hDEAD);
                else chk("r_data", r_data, q_r.pop_front());
            end
            if (hs[4]) begin
                if (q_b.size() == 0) chk("b_unexpected", 64'(b_data), 64'hDEAD);
                else chk("b_data", 64'(b_data), 64'(q_b.pop_front()));
            end
            prev_hs = hs;
        end
    end

    // One-cycle payload offer; expected beats are queued only when the vector says it is accepted.
    task automatic send(input logic [2:0] hdr, input logic [63:0] ch, input logic bv,
                        input logic [7:0] b, input logic exp_rdy);
        in_valid = 1'b1; in_hdr = hdr; in_ch = ch; in_bv = bv; in_b = b;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_rdy) begin
            case (hdr)
                3'd1: q_aw.push_back(ch);
                3'd2: q_w.push_back(ch);
                3'd3: q_ar.push_back(ch);
                3'd4: q_r.push_back(ch);
                default: ;
            endcase
            if (bv) q_b.push_back(b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_bv = 1'b0; in_hdr = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valids", 64'({aw_valid, w_valid, ar_valid, r_valid, b_valid}), 64'h0);
        chk("rst_credit", 64'(credit_only), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_err_cnt", 64'(err_cnt), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        @(posedge clk); #1;

        // Idle without B: credit-only pulse for exactly one cycle.
        send(3'd0, 64'h0, 1'b0, 8'h0, 1'b1);
        @(negedge clk);
        chk("credit_pulse", 64'(credit_only), 64'h1);
        chk("idle_no_valids", 64'({aw_valid, w_valid, ar_valid, r_valid, b_valid}), 64'h0);
        @(negedge clk);
        chk("credit_clear", 64'(credit_only), 64'h0);
        @(posedge clk); #1;

        // AW + B in one payload, held under backpressure.
        send(3'd1, 64'hA5, 1'b1, 8'h3, 1'b1);
        @(negedge clk);
        chk("aw_b_valid", 64'({aw_valid, b_valid}), 64'h3);
        chk("credit_not_for_aw", 64'(credit_only), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("aw_hold", aw_data, 64'hA5);
            chk("b_hold", 64'(b_data), 64'h3);
        end
        @(posedge clk); #1;
        aw_ready = 1'b1; b_ready = 1'b1;
        @(posedge clk); #1;
        aw_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        chk("freed_aw_b", 64'(freed), 64'h11);
        chk("aw_drained", 64'(aw_valid), 64'h0);
        @(posedge clk); #1;

        // W fills while blocked; AR still gets through.
        for (int i = 1; i <= 4; i++) send(3'd2, 64'(i), 1'b0, 8'h0, 1'b1);
        send(3'd2, 64'h5, 1'b0, 8'h0, 1'b0);
        send(3'd3, 64'h77, 1'b0, 8'h0, 1'b1);
        w_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 ar_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("w_order_drained", 64'(q_w.size()), 64'h0);

        // B FIFO full blocks an R+B payload atomically.
        for (int i = 1; i <= 4; i++) begin
            send(3'd0, 64'h0, 1'b1, 8'(i), 1'b1);
            if (i == 1) begin
                @(negedge clk);
                chk("credit_not_with_b", 64'(credit_only), 64'h0);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_hdr = 3'd4; in_ch = 64'h44; in_bv = 1'b1; in_b = 8'h5;
        @(negedge clk);
        chk("b_full_block", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        chk("r_not_pushed", 64'(r_valid), 64'h0);
        b_ready = 1'b1;
        @(negedge clk);
        chk("b_pop_same_cycle", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        b_ready = 1'b0;
        @(negedge clk);
        chk("b_pop_next_cycle", 64'(in_ready), 64'h1);
        q_r.push_back(64'h44); q_b.push_back(8'h5);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bv = 1'b0; in_hdr = 3'd0;
        r_ready = 1'b1; b_ready = 1'b1; aw_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Illegal tag stream: sticky error and saturating counter.
        in_valid = 1'b1; in_hdr = 3'd6; in_ch = 64'hFF; in_bv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("err_set", 64'(err), 64'h1);
        chk("err_cnt_1", 64'(err_cnt), 64'h1);
        repeat (299) @(posedge clk);
        #1 in_valid = 1'b0; in_hdr = 3'd0;
        @(negedge clk);
        chk("err_cnt_sat", 64'(err_cnt), 64'hFF);
        chk("err_sticky", 64'(err), 64'h1);
        chk("illegal_no_valids", 64'({aw_valid, w_valid, ar_valid, r_valid, b_valid}), 64'h0);
        @(posedge clk); #1;

        // Reset with buffered AW beats discards them without free pulses.
        aw_ready = 1'b0;
        send(3'd1, 64'h11, 1'b0, 8'h0, 1'b1);
        send(3'd1, 64'h22, 1'b0, 8'h0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_aw", 64'(aw_valid), 64'h0);
        chk("rst_async_freed", 64'(freed), 64'h0);
        chk("rst_async_err", 64'(err), 64'h0);
        q_aw.delete();
        aw_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_aw", 64'(aw_valid), 64'h0);
        chk("post_rst_cnt", 64'(err_cnt), 64'h0);
        @(posedge clk); #1;
        send(3'd1, 64'h33, 1'b0, 8'h0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(q_aw.size() + q_w.size() + q_ar.size() + q_r.size() + q_b.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
